// File: rtl/bg_pkg.sv
// Shared timing constants and BRAM-issuer tag type for the background fetch path.
package bg_pkg;

  localparam int unsigned H_TOTAL        = 800;  // pixel clocks per line
  localparam int unsigned V_TOTAL        = 525;  // lines per frame
  localparam int unsigned H_ACTIVE       = 640;  // visible pixels per line
  localparam int unsigned V_ACTIVE       = 480;  // visible lines
  localparam int unsigned WORDS_PER_LINE = 80;   // H_ACTIVE / 8

  // Who issued the BRAM read that is travelling down the latency pipeline.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_FETCH,
    TAG_HOST
  } bram_tag_t;

endpackage

// File: rtl/bg_addr_gen.sv
// Background word address generator.
// Wraps (line + vertical scroll) into the visible rows and (word + horizontal scroll) into
// one line of words, then forms BASE_ADDR + row*80 + col.
// Ports:
//   line_i  - display line being fetched (0..V_ACTIVE-1)
//   word_i  - word index within that line (0..WORDS_PER_LINE-1)
//   sy_i    - latched vertical scroll in lines
//   sx_i    - latched horizontal scroll in words
//   addr_o  - BRAM word address
module bg_addr_gen import bg_pkg::*; #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic [9:0]        line_i,
  input  logic [6:0]        word_i,
  input  logic [8:0]        sy_i,
  input  logic [6:0]        sx_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [9:0]  row_sum;
  logic [9:0]  row;
  logic [7:0]  col_sum;
  logic [7:0]  col;
  logic [15:0] row_x80;

  always_comb begin
    row_sum = line_i + {1'b0, sy_i};
    row     = (row_sum >= 10'(V_ACTIVE)) ? row_sum - 10'(V_ACTIVE) : row_sum;
    col_sum = {1'b0, word_i} + {1'b0, sx_i};
    col     = (col_sum >= 8'(WORDS_PER_LINE)) ? col_sum - 8'(WORDS_PER_LINE) : col_sum;
    // row * 80 as two shifts, no multiplier
    row_x80 = ({6'd0, row} << 6) + ({6'd0, row} << 4);
    addr_o  = ADDR_W'(BASE_ADDR) + ADDR_W'(row_x80) + ADDR_W'(col);
  end

endmodule

// File: rtl/background_fetch_scheduler.sv
// Background frame-buffer fetch scheduler.
// Issues BRAM reads so background_data holds the word covering the current 8-pixel group,
// updated on the edge that ends DrawX%8==7. Host accesses use every BRAM cycle that display
// fetch leaves free; fetch always wins.
// Ports:
//   clk, reset            - pixel clock, synchronous active-high reset
//   DrawX, DrawY          - current raster position
//   scroll_x, scroll_y    - scroll request, latched at the start of vblank
//   background_data       - current background word (nibble n = pixel DrawX%8==n)
//   bram_*                - single BRAM port (read data READ_LAT cycles after issue)
//   host_req/we/addr/wdata- host request, held until host_gnt
//   host_gnt              - access issued to BRAM this cycle
//   host_rdata/rvalid     - read return, READ_LAT cycles after a granted read
module background_fetch_scheduler import bg_pkg::*; #(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [6:0]        scroll_x,
  input  logic [8:0]        scroll_y,
  output logic [31:0]       background_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid
);

  logic [6:0]        sx_q;
  logic [8:0]        sy_q;
  logic [9:0]        pos_ahead;
  logic [6:0]        grp_ahead;
  logic [9:0]        next_line;
  logic              inline_hit;
  logic              pre_hit;
  logic              fetch_d;
  logic              fetch_q;
  logic [9:0]        fetch_line;
  logic [6:0]        fetch_word;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_addr_q;
  bram_tag_t         tag_q [READ_LAT];
  bram_tag_t         tag_out;
  bram_tag_t         issue_tag;
  logic [31:0]       bg_data_q;
  logic [31:0]       rdata_q;

  // Decode the slot one cycle ahead so the registered address lands on the slot cycle.
  // A slot at DrawX == 8k+7-READ_LAT is decided at DrawX+1+READ_LAT == 8k+7.
  always_comb begin
    pos_ahead  = DrawX + 10'(READ_LAT + 1);
    grp_ahead  = pos_ahead[9:3];
    next_line  = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    inline_hit = (DrawY < 10'(V_ACTIVE)) && (pos_ahead[2:0] == 3'd7) &&
                 (grp_ahead <= 7'(WORDS_PER_LINE - 2));
    pre_hit    = (DrawX == 10'(H_TOTAL - 2 - READ_LAT)) && (next_line < 10'(V_ACTIVE));
    fetch_d    = inline_hit || pre_hit;
    fetch_line = pre_hit ? next_line : DrawY;
    fetch_word = pre_hit ? 7'd0 : grp_ahead + 7'd1;
  end

  bg_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_gen (
    .line_i(fetch_line),
    .word_i(fetch_word),
    .sy_i  (sy_q),
    .sx_i  (sx_q),
    .addr_o(fetch_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q <= 7'd0;
      sy_q <= 9'd0;
    end else if (DrawX == 10'd0 && DrawY == 10'(V_ACTIVE)) begin
      sx_q <= (scroll_x < 7'(WORDS_PER_LINE)) ? scroll_x : 7'd0;
      sy_q <= (scroll_y < 9'(V_ACTIVE)) ? scroll_y : 9'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q      <= 1'b0;
      fetch_addr_q <= '0;
    end else begin
      fetch_q      <= fetch_d;
      fetch_addr_q <= fetch_addr;
    end
  end

  // Host is granted combinationally in any cycle that is not a fetch slot.
  always_comb begin
    host_gnt  = !reset && host_req && !fetch_q;
    bram_en   = !reset && (fetch_q || host_req);
    bram_we   = host_gnt && host_we;
    bram_addr = fetch_q ? fetch_addr_q : (host_gnt ? host_addr : '0);
    bram_din  = host_gnt ? host_wdata : 32'd0;
    issue_tag = fetch_q ? TAG_FETCH : ((host_gnt && !host_we) ? TAG_HOST : TAG_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LAT); i++) tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < int'(READ_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_data_q <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      if (tag_out == TAG_FETCH) bg_data_q <= bram_dout;
      if (tag_out == TAG_HOST)  rdata_q   <= bram_dout;
    end
  end

  always_comb begin
    background_data = bg_data_q;
    host_rvalid     = (tag_out == TAG_HOST);
    host_rdata      = host_rvalid ? bram_dout : rdata_q;
  end

endmodule

// File: tb/tb_background_fetch_scheduler.sv
module tb_background_fetch_scheduler;

  localparam int RL = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  draw_x, draw_y;
  logic [6:0]  scroll_x;
  logic [8:0]  scroll_y;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;

  logic [31:0] bd, din, dout, rdata;
  logic        en, we, gnt, rvalid;
  logic [15:0] addr;

  logic [31:0] bd1, din1, dout1, rdata1;
  logic        en1, we1, gnt1, rvalid1;
  logic [15:0] addr1;
  logic [31:0] bd6, din6, dout6, rdata6;
  logic        en6, we6, gnt6, rvalid6;
  logic [15:0] addr6;

  background_fetch_scheduler #(.READ_LAT(RL), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .background_data(bd),
    .bram_en(en), .bram_we(we), .bram_addr(addr), .bram_din(din), .bram_dout(dout),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt), .host_rdata(rdata), .host_rvalid(rvalid)
  );

  background_fetch_scheduler #(.READ_LAT(1), .ADDR_W(16), .BASE_ADDR(0)) dut_l1 (
    .clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .background_data(bd1),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_din(din1), .bram_dout(dout1),
    .host_req(1'b0), .host_we(1'b0), .host_addr(16'd0), .host_wdata(32'd0),
    .host_gnt(gnt1), .host_rdata(rdata1), .host_rvalid(rvalid1)
  );

  background_fetch_scheduler #(.READ_LAT(6), .ADDR_W(16), .BASE_ADDR(0)) dut_l6 (
    .clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .background_data(bd6),
    .bram_en(en6), .bram_we(we6), .bram_addr(addr6), .bram_din(din6), .bram_dout(dout6),
    .host_req(1'b0), .host_we(1'b0), .host_addr(16'd0), .host_wdata(32'd0),
    .host_gnt(gnt6), .host_rdata(rdata6), .host_rvalid(rvalid6)
  );

  // BRAM models: word[a] = a, plus a single-entry store for host writes on the main port.
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = 16'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] mpipe0, mpipe1;
  logic [15:0] p6 [0:5];
  logic [31:0] dout1_q;

  function automatic logic [31:0] rd_val(input logic [15:0] a);
    return (wr_valid && a == wr_addr) ? wr_data : {16'd0, a};
  endfunction

  always @(posedge clk) begin
    mpipe0 <= rd_val(addr);
    mpipe1 <= mpipe0;
    if (en && we) begin
      wr_valid <= 1'b1;
      wr_addr  <= addr;
      wr_data  <= din;
    end
    dout1_q <= {16'd0, addr1};
    p6[0] <= addr6;
    for (int i = 1; i < 6; i++) p6[i] <= p6[i-1];
  end

  assign dout  = mpipe1;
  assign dout1 = dout1_q;
  assign dout6 = {16'd0, p6[5]};

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nogrant;
  bit          wrote5 = 1'b0;
  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int line, input int k, input int sx,
                                           input int sy);
    int a;
    a = ((line + sy) % 480) * 80 + ((k + sx) % 80);
    return (wrote5 && a == 5) ? 32'hDEADBEEF : a;
  endfunction

  function automatic bit is_slot(input int x, input int y);
    int nl;
    nl = (y == 524) ? 0 : y + 1;
    if (y < 480 && x + RL >= 7 && (x + RL - 7) % 8 == 0 && (x + RL - 7) / 8 <= 78) return 1'b1;
    if (x == 799 - RL && nl < 480) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: inputs move 1 after the edge, outputs are sampled 2 after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (draw_x == 10'd799) begin
      draw_x = 10'd0;
      draw_y = (draw_y == 10'd524) ? 10'd0 : draw_y + 10'd1;
    end else begin
      draw_x = draw_x + 10'd1;
    end
    #1;
    if (rvalid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        chk("spurious_rvalid", {31'd0, rvalid}, 32'd0);
      end else begin
        chk("host_rdata", rdata, exp_data_q.pop_front());
        chk("rvalid_cycle", cyc, exp_cyc_q.pop_front());
      end
    end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
      chk("rvalid_missing", {31'd0, rvalid}, 32'd1);
      void'(exp_data_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i < 420000; i++) begin
      if (draw_x == x && draw_y == y) break;
      step();
    end
  endtask

  task automatic set_pos(input int x, input int y);
    draw_x = x[9:0];
    draw_y = y[9:0];
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp);
    chk({tag, "_rl2"}, bd, exp);
    chk({tag, "_rl1"}, bd1, exp);
    chk({tag, "_rl6"}, bd6, exp);
  endtask

  initial begin
    reset = 1'b1; scroll_x = 7'd0; scroll_y = 9'd0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'd0; host_wdata = 32'd0;
    set_pos(780, 524);
    step(); step(); step();
    chk("rst_bd", bd, 32'd0);
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_addr", {16'd0, addr}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    host_req = 1'b1; #1;
    chk("rst_gnt_blocked", {31'd0, gnt}, 32'd0);
    chk("rst_en_blocked", {31'd0, en}, 32'd0);
    host_req = 1'b0; #1;
    reset = 1'b0; #1;

    // Scroll 0, free-running raster
    run_to(0, 0);
    chk_all("l0_w0", exp_word(0, 0, 0, 0));
    run_to(5, 0);
    chk("slot_en", {31'd0, en}, 32'd1);
    chk("slot_addr", {16'd0, addr}, exp_word(0, 1, 0, 0));
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'hDEADBEEF; #1;
    chk("wr_gnt_in_slot", {31'd0, gnt}, 32'd0);
    chk("slot_addr_fetch_wins", {16'd0, addr}, 32'd1);
    chk("slot_we", {31'd0, we}, 32'd0);
    step();
    chk("wr_gnt_x6", {31'd0, gnt}, 32'd1);
    chk("wr_we", {31'd0, we}, 32'd1);
    chk("wr_addr", {16'd0, addr}, 32'd5);
    chk("wr_din", din, 32'hDEADBEEF);
    step();
    host_req = 1'b0; host_we = 1'b0; wrote5 = 1'b1; #1;
    chk_all("x7_hold", exp_word(0, 0, 0, 0));
    step();
    chk_all("x8_word1", exp_word(0, 1, 0, 0));

    // Host read of the written word
    run_to(10, 0);
    host_req = 1'b1; host_addr = 16'd5; #1;
    exp_data_q.push_back(32'hDEADBEEF);
    exp_cyc_q.push_back(cyc + RL);
    chk("rd_gnt", {31'd0, gnt}, 32'd1);
    step();
    host_req = 1'b0; #1;
    run_to(15, 0);
    chk("x15_unaffected", bd, exp_word(0, 1, 0, 0));
    step();
    chk("x16_word2", bd, exp_word(0, 2, 0, 0));
    run_to(40, 0);
    chk("rewritten_word5", bd, exp_word(0, 5, 0, 0));
    run_to(632, 1);
    chk_all("l1_w79", exp_word(1, 79, 0, 0));

    // Continuous host reads across visible line 2
    run_to(0, 2);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd100; #1;
    nogrant = 0;
    for (int i = 0; i < 800; i++) begin
      chk("cont_gnt", {31'd0, gnt}, {31'd0, !is_slot(draw_x, draw_y)});
      if (!gnt) nogrant++;
      if (!is_slot(draw_x, draw_y)) begin
        exp_data_q.push_back(32'd100);
        exp_cyc_q.push_back(cyc + RL);
      end
      if (draw_x % 8 == 0 && draw_x < 640) chk("line2_word", bd, exp_word(2, draw_x / 8, 0, 0));
      step();
    end
    host_req = 1'b0; #1;
    chk("nogrant_count", nogrant, 32'd80);

    // Reset with a fetch and a host read in flight
    run_to(14, 3);
    host_req = 1'b1; host_addr = 16'd9; #1;
    chk("inflight_rd_gnt", {31'd0, gnt}, 32'd1);
    step();
    host_req = 1'b0; reset = 1'b1; #1;
    step();
    chk("midrst_bd", bd, 32'd0);
    chk("midrst_en", {31'd0, en}, 32'd0);
    chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    reset = 1'b0; #1;
    run_to(23, 3);
    chk("postrst_bd_hold", bd, 32'd0);
    chk("postrst_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    chk("postrst_word3", bd, exp_word(3, 3, 0, 0));
    run_to(40, 3);

    // Scroll wrap in both directions
    scroll_x = 7'd78; scroll_y = 9'd479;
    set_pos(790, 479);
    run_to(1, 480);
    set_pos(780, 524);
    run_to(0, 0);
    chk_all("scr_l0_w0", exp_word(0, 0, 78, 479));
    run_to(8, 0);
    chk_all("scr_l0_w1", exp_word(0, 1, 78, 479));
    run_to(16, 0);
    chk_all("scr_l0_w2", exp_word(0, 2, 78, 479));
    run_to(0, 1);
    chk_all("scr_l1_w0", exp_word(1, 0, 78, 479));

    // Out-of-range scroll latches as 0
    scroll_x = 7'd100; scroll_y = 9'd500;
    set_pos(790, 479);
    run_to(1, 480);
    set_pos(780, 524);
    run_to(0, 0);
    chk_all("oor_l0_w0", exp_word(0, 0, 0, 0));
    run_to(8, 0);
    chk_all("oor_l0_w1", exp_word(0, 1, 0, 0));
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/background_fetch_scheduler.md
Name: background_fetch_scheduler

Overview:
- Sequences background frame-buffer BRAM reads so that `background_data` always holds the 32-bit word (8 × 4-bpp pixels) covering the current `DrawX`/`DrawY`.
- The word is placed at the exact cycle the background colour mapper needs it.
- Shares the single BRAM port between display fetch (fixed priority) and a host read/write requester, using the slots that fetch leaves free.
- Applies frame-latched horizontal (word-granular) and vertical scroll.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- WORDS_PER_LINE, 80, H_ACTIVE/8
- READ_LAT, 2, BRAM read latency in cycles; legal 1..6
- ADDR_W, 16, BRAM word address width
- BASE_ADDR, 0, word address of frame-buffer row 0

Ports:
- clk  in  1  pixel clock, one DrawX step per cycle
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column from VGA controller
- DrawY  in  10  current line from VGA controller
- scroll_x  in  7  horizontal scroll in words, 0..79
- scroll_y  in  9  vertical scroll in lines, 0..479
- background_data  out  32  word for current 8-pixel group; nibble n = pixel DrawX%8==n
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  32  BRAM write data
- bram_dout  in  32  BRAM read data, valid READ_LAT cycles after issue
- host_req  in  1  host access request; held with fields stable until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  32  host write data
- host_gnt  out  1  one-cycle pulse: request issued to BRAM this cycle
- host_rdata  out  32  host read data
- host_rvalid  out  1  one-cycle pulse, READ_LAT cycles after a granted read

Behaviour:
- Reset values:
  - background_data, bram_addr, bram_din, host_rdata all 0.
  - bram_en, bram_we, host_gnt, host_rvalid all 0.
  - Latched scroll values 0; tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them.
- Scroll latch:
  - At DrawX==0 && DrawY==V_ACTIVE (start of vblank), sy_l <= scroll_y and sx_l <= scroll_x.
  - An out-of-range input (scroll_x ≥ 80 or scroll_y ≥ 480) latches as 0.
- Fetch slots (fetch has absolute priority):
  - In-line slot: on a visible line (DrawY < V_ACTIVE), when DrawX == 8k + 7 − READ_LAT for k = 0..WORDS_PER_LINE−2, fetch word k+1 of line DrawY.
  - Prefetch slot: when DrawX == H_TOTAL − 1 − READ_LAT, fetch word 0 of the next line L.
    - L = DrawY+1, or L = 0 when DrawY == V_TOTAL−1.
    - Only issued if L < V_ACTIVE.
- Address arithmetic:
  - row = (line + sy_l), minus 480 if ≥ 480.
  - col = (k + sx_l), minus 80 if ≥ 80.
  - addr = BASE_ADDR + row·80 + col, with row·80 computed as (row<<6)+(row<<4).
  - Combinational address feeds a registered bram_addr; slot comparisons are made one cycle earlier to absorb that register stage. This is internal detail; the externally checked timing is that the address is presented at the slot cycle above.
- Capture:
  - A READ_LAT-deep tag shift register records the issuer of each read: {fetch, host, none}.
  - When the tag at the output is fetch, background_data <= bram_dout.
  - As a result, background_data changes only on the clock edge ending a cycle with DrawX%8==7; the new word is visible when DrawX%8==0.
  - Otherwise background_data holds its value, including through blanking.
- Host arbitration:
  - In any cycle that is not a fetch slot with host_req=1: issue host access and pulse host_gnt in that same cycle.
  - Writes complete at issue.
  - Reads return host_rdata with host_rvalid READ_LAT cycles later.
- Simultaneous events:
  - Fetch slot + host_req: the host waits; no gnt that cycle.
  - Back-to-back host requests may be granted on consecutive cycles.
- Host write to the word currently displayed: the display shows the new value only on that word's next fetch. No bypass.

Decomposition:
- Package bg_pkg:
  - Timing constants H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE, WORDS_PER_LINE.
  - Enum typedef bram_tag_t {TAG_NONE, TAG_FETCH, TAG_HOST}.
- Sub-module bg_addr_gen: combinational row/col wrap plus row·80 + col + BASE_ADDR.

Test Plan:
- Reset release, free-running DrawX/DrawY, BRAM model with word[a] = a, scroll 0 → at DrawX=0,DrawY=0, background_data = 0; at DrawX=8 it is 1; at DrawX=632,DrawY=1 it is 80+79 = 159.
- scroll_x=78, scroll_y=479 presented before line 480 → line 0 word 0 = 479·80+78 = 38398; word 2 = 479·80+0 = 38320; line 1 word 0 = 78.
- scroll_x=100 → latched as 0; line 0 word 0 = 0.
- Host write addr 5, data 32'hDEADBEEF, asserted with DrawX=5,DrawY=0 (a fetch slot when READ_LAT=2) → host_gnt at DrawX=6, not 5.
- Host read addr 5 after the previous write → host_rvalid exactly 2 cycles after gnt, host_rdata = 32'hDEADBEEF; background_data unaffected.
- Continuous host_req across a full visible line → exactly 80 cycles without grant (79 in-line + 1 prefetch) out of 800; all fetched words correct.
- Reset asserted with a fetch in flight → after release, background_data = 0 and no host_rvalid pulse appears.
- Repeat the first scenario with READ_LAT=1 and 6 → same background_data values at the same DrawX.
